axi_config_rd_pipe: RTL and testbench
=====================================

# axi_config_rd_pipe

Parametrised AXI4 read-only slave bridging bursts onto a simple pipelined register-read port (`rd`/`raddr` → `rdata`/`rvalid`). It generalises the fixed 4-entry configuration read path with a configurable response FIFO, credit-based read issue (the FIFO can never overflow), FIXED/INCR/WRAP burst addressing derived from `arsize`, and per-beat error reporting. It sits between the AXI interconnect and a block's configuration/status register file.

## Interface

Parameters:
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- STRB_WIDTH, DATA_WIDTH/8: bytes per beat; must be a power of two.
- ID_WIDTH, 8: ID width.
- ARUSER_ENABLE, 0 / ARUSER_WIDTH, 1: aruser is accepted and ignored.
- RUSER_ENABLE, 0 / RUSER_WIDTH, 1: ruser is driven to 0.
- FIFO_DEPTH, 4: response FIFO entries; power of two, ≥2. This is also the maximum number of outstanding backend reads.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset. One clock; reset is synchronous and active-high.
- s_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}, in: AXI4 AR channel, standard widths.
- s_axi_arready, out, 1.
- s_axi_rid, out, ID_WIDTH.
- s_axi_rdata, out, DATA_WIDTH.
- s_axi_rresp, out, 2.
- s_axi_rlast, out, 1.
- s_axi_ruser, out, RUSER_WIDTH.
- s_axi_rvalid, out, 1.
- s_axi_rready, in, 1.
- rd, out, 1: one-cycle read strobe per beat.
- raddr, out, ADDR_WIDTH: read address, valid while rd=1.
- rdata, in, DATA_WIDTH: read data, qualified by rvalid.
- rerr, in, 1: error flag for this response, qualified by rvalid.
- rvalid, in, 1: backend response. Responses return in order, with any latency ≥1 cycle after the matching rd.

## Operation

- State machine with two states:
  - IDLE: arready=1. On AR handshake, latch id, addr, beats = arlen+1 (9-bit), size = min(arsize, log2(STRB_WIDTH)), and burst; go to BURST with arready=0.
  - BURST: issue reads and drain the FIFO. When the R handshake with rlast=1 completes, go to IDLE.
- Issue rule: rd=1 in a cycle iff issued < beats AND (outstanding + fifo_count) < FIFO_DEPTH, where outstanding = issued − received.
- Address step after each issued rd:
  - FIXED (0): unchanged.
  - INCR (1): addr += 1<<size.
  - WRAP (2): addr += 1<<size within an aligned window of (beats << size) bytes; it wraps to the window base. If len∉{1,3,7,15}, WRAP is treated as INCR.
  - Reserved (3): treated as INCR.
- Address arithmetic is modulo 2^ADDR_WIDTH.
- FIFO: push {rerr, rdata} on rvalid while in BURST. Pop on s_axi_rvalid && s_axi_rready. Simultaneous push and pop leaves the count unchanged.
- R channel:
  - s_axi_rvalid = FIFO non-empty; rdata is the FIFO head.
  - rresp = 2'b10 (SLVERR) if the head's rerr=1, else 2'b00.
  - rid = latched id.
  - rlast=1 iff the head is beat beats−1 (delivered counter).
  - An error beat does not abort the burst.
- rvalid arriving in IDLE is dropped.
- Reset values: arready=0 during reset (1 from the first cycle after); rd=0, raddr=0, s_axi_rvalid=0, rlast=0, rid=0, rresp=0, ruser=0. All counters and the FIFO pointers are cleared.
- Reset mid-burst abandons the burst and discards FIFO contents. The backend must be reset in the same cycle.

## Timing

- AR handshake at cycle T: rd=1 with raddr=araddr at T+1.
- Subsequent rd pulses are back-to-back while credits allow.
- FIFO write at cycle C gives s_axi_rvalid=1 at C+1 (registered count). With backend latency L, the first beat is visible at T+L+2.
- Sustained throughput is 1 beat/cycle with rready=1 when FIFO_DEPTH ≥ L+2. Otherwise rd stalls and is never dropped.
- A stalled R channel (rready=0) holds rdata, rresp, and rlast stable. The issue count throttles to credits.
- arready reasserts the cycle after the final R handshake. A new AR is accepted no earlier than that cycle.

## Test plan

- INCR, araddr=0x100, arlen=3, arsize=2, L=1, rready=1 → raddr 0x100/0x104/0x108/0x10C on consecutive cycles; 4 beats with rlast on beat 3; rresp=0; rid echoed.
- WRAP, araddr=0x38, arlen=3, arsize=2 → raddr 0x38, 0x3C, 0x30, 0x34.
- FIXED, arlen=7, with rready held low for 10 cycles → exactly FIFO_DEPTH rd pulses, then no more until pops. All 8 beats eventually delivered in order from addr constant.
- rerr=1 on beat 2 of a 4-beat burst → rresp 00, 00, 10, 00; burst completes; arready=1 the cycle after the last handshake.
- arlen=0 → single rd, single beat with rlast=1. Then back-to-back AR accepted the cycle after the R handshake.
- rst asserted mid-burst (beat 2 of 8) → next cycle rvalid=0, rd=0, arready=0; arready=1 after release. A fresh burst returns correct data with no stale beats.

Source files
------------

// File: rtl/axi_config_rd_pipe.sv
// AXI4 read-only slave that turns AR bursts into single-beat register reads.
// Responses are buffered in a small FIFO; reads are issued only against free FIFO credits.
module axi_config_rd_pipe #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int ARUSER_ENABLE = 0,
  parameter int ARUSER_WIDTH  = 1,
  parameter int RUSER_ENABLE  = 0,
  parameter int RUSER_WIDTH   = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    rd,
  output logic [ADDR_WIDTH-1:0]   raddr,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    rerr,
  input  logic                    rvalid
);
  localparam int SIZE_MAX = $clog2(STRB_WIDTH);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                  state_q;
  logic                    arready_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   step_q, wrap_mask_q;
  logic                    fixed_q;
  logic [8:0]              beats_q, issued_q, received_q, delivered_q;
  logic [CNT_W-1:0]        count_q;
  logic [PTR_W-1:0]        wptr_q, rptr_q;
  logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];

  logic                    ar_hs, push, pop, fifo_nempty, credit_ok, head_last;
  logic [8:0]              outstanding, beats_ar;
  logic [2:0]              size_ar;
  logic                    wrap_ok;
  logic [DATA_WIDTH:0]     head;

  assign ar_hs       = arready_q && s_axi_arvalid;
  assign fifo_nempty = (count_q != '0);
  assign outstanding = issued_q - received_q;
  assign credit_ok   = (10'(outstanding) + 10'(count_q)) < 10'(FIFO_DEPTH);
  assign rd          = (state_q == BURST) && (issued_q < beats_q) && credit_ok;
  assign raddr       = addr_q;
  assign push        = rvalid && (state_q == BURST);
  assign pop         = fifo_nempty && s_axi_rready;
  assign head        = mem[rptr_q];
  assign head_last   = (delivered_q == beats_q - 9'd1);

  assign beats_ar = {1'b0, s_axi_arlen} + 9'd1;
  assign size_ar  = (s_axi_arsize > 3'(SIZE_MAX)) ? 3'(SIZE_MAX) : s_axi_arsize;
  assign wrap_ok  = (s_axi_arburst == 2'b10) &&
                    (s_axi_arlen == 8'd1 || s_axi_arlen == 8'd3 ||
                     s_axi_arlen == 8'd7 || s_axi_arlen == 8'd15);

  // A mask of all ones makes the wrap formula collapse to a plain increment.
  assign addr_d = fixed_q ? addr_q
                : ((addr_q & ~wrap_mask_q) | ((addr_q + step_q) & wrap_mask_q));

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = fifo_nempty;
  assign s_axi_rid     = id_q;
  assign s_axi_rdata   = fifo_nempty ? head[DATA_WIDTH-1:0] : '0;
  assign s_axi_rresp   = (fifo_nempty && head[DATA_WIDTH]) ? 2'b10 : 2'b00;
  assign s_axi_rlast   = fifo_nempty && head_last;
  assign s_axi_ruser   = '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {rerr, rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      step_q      <= '0;
      wrap_mask_q <= '0;
      fixed_q     <= 1'b0;
      beats_q     <= '0;
      issued_q    <= '0;
      received_q  <= '0;
      delivered_q <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      if (rd) begin
        issued_q <= issued_q + 9'd1;
        addr_q   <= addr_d;
      end
      if (push) begin
        received_q <= received_q + 9'd1;
        wptr_q     <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        delivered_q <= delivered_q + 9'd1;
        rptr_q      <= rptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase

      case (state_q)
        IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q   <= 1'b0;
            state_q     <= BURST;
            id_q        <= s_axi_arid;
            addr_q      <= s_axi_araddr;
            beats_q     <= beats_ar;
            step_q      <= ADDR_WIDTH'(1) << size_ar;
            fixed_q     <= (s_axi_arburst == 2'b00);
            wrap_mask_q <= wrap_ok ? ((ADDR_WIDTH'(beats_ar) << size_ar) - ADDR_WIDTH'(1)) : '1;
            issued_q    <= '0;
            received_q  <= '0;
            delivered_q <= '0;
          end
        end
        BURST: begin
          if (pop && head_last) begin
            state_q   <= IDLE;
            arready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                       s_axi_arregion, s_axi_aruser};
endmodule

// File: tb/tb_axi_config_rd_pipe.sv
// Scoreboard bench: stimulus queues expected addresses/beats, negedge monitors pop and compare.
module tb_axi_config_rd_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic [0:0]  s_axi_ruser;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        rd;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        rerr;
  logic        rvalid;

  always #5 clk = ~clk;

  axi_config_rd_pipe dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0), .s_axi_arregion(4'd0),
    .s_axi_aruser(1'b0), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .rd(rd), .raddr(raddr), .rdata(rdata), .rerr(rerr),
    .rvalid(rvalid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [7:0]  id;
  } rexp_t;

  rexp_t       exp_r[$];
  logic [31:0] exp_a[$];

  // Backend: fixed latency lat, data tagged with beat sequence number and address.
  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } pend_t;
  pend_t pend[$];
  int    cyc = 0;
  int    seq = 0;
  int    lat = 1;
  int    err_beat = -1;
  int    rd_count = 0;

  always @(negedge clk) begin
    pend_t p;
    rvalid = 1'b0;
    rerr   = 1'b0;
    if (rst) begin
      pend.delete();
      seq = 0;
    end else begin
      cyc++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        rvalid = 1'b1;
        rdata  = p.data;
        rerr   = p.err;
      end
      if (s_axi_arvalid && s_axi_arready) seq = 0;
      if (rd) begin
        p.due  = cyc + lat;
        p.data = {seq[7:0], raddr[23:0]};
        p.err  = (seq == err_beat);
        pend.push_back(p);
        seq++;
      end
    end
  end

  // rd / raddr monitor
  always @(negedge clk) begin
    if (!rst && rd) begin
      rd_count++;
      if (exp_a.size() == 0) chk("rd_extra", {32'd0, raddr}, 64'hFFFF_FFFF);
      else chk("raddr", {32'd0, raddr}, {32'd0, exp_a.pop_front()});
    end
  end

  // R channel monitor, including hold-stable check while stalled
  logic        hold_v = 1'b0;
  logic [34:0] held;
  always @(negedge clk) begin
    rexp_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        chk("stall_hold", {28'd0, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast},
            {28'd0, 1'b1, held});
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r.size() == 0) begin
          chk("r_extra", {32'd0, s_axi_rdata}, 64'hFFFF_FFFF);
        end else begin
          e = exp_r.pop_front();
          chk("rdata", {32'd0, s_axi_rdata}, {32'd0, e.data});
          chk("rresp", {62'd0, s_axi_rresp}, {62'd0, e.resp});
          chk("rlast", {63'd0, s_axi_rlast}, {63'd0, e.last});
          chk("rid",   {56'd0, s_axi_rid},   {56'd0, e.id});
        end
      end
      hold_v = s_axi_rvalid && !s_axi_rready;
      held   = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
    end
  end

  task automatic add_beat(input logic [31:0] a, input int k, input bit last,
                          input bit err, input logic [7:0] id);
    rexp_t e;
    exp_a.push_back(a);
    e.data = {k[7:0], a[23:0]};
    e.resp = err ? 2'b10 : 2'b00;
    e.last = last;
    e.id   = id;
    exp_r.push_back(e);
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (s_axi_arready) done = 1;
      @(posedge clk); #1;
    end
    s_axi_arvalid = 1'b0;
    chk("ar_accept", {63'd0, done}, 64'd1);
    chk("first_rd", {31'd0, rd, raddr}, {31'd0, 1'b1, a});
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #1;
      if (exp_r.size() == 0 && exp_a.size() == 0) done = 1;
    end
    chk("drain", {63'd0, done}, 64'd1);
    chk("arready_after_last", {63'd0, s_axi_arready}, 64'd1);
    chk("rvalid_after_last", {63'd0, s_axi_rvalid}, 64'd0);
  endtask

  initial begin
    bit reached;
    rst = 1'b1; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", {63'd0, s_axi_arready}, 64'd0);
    chk("rst_outputs", {49'd0, s_axi_rvalid, rd, s_axi_rlast, s_axi_rid, s_axi_rresp, s_axi_ruser, raddr[0]},
        64'd0);
    chk("rst_raddr", {32'd0, raddr}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_arready", {63'd0, s_axi_arready}, 64'd1);

    // INCR 4 beats, latency 1
    for (int k = 0; k < 4; k++) add_beat(32'h100 + 32'(4 * k), k, k == 3, 0, 8'h11);
    send_ar(8'h11, 32'h100, 8'd3, 3'd2, 2'b01);
    wait_done();

    // WRAP 4 beats, latency 3
    lat = 3;
    add_beat(32'h38, 0, 0, 0, 8'h22);
    add_beat(32'h3C, 1, 0, 0, 8'h22);
    add_beat(32'h30, 2, 0, 0, 8'h22);
    add_beat(32'h34, 3, 1, 0, 8'h22);
    send_ar(8'h22, 32'h38, 8'd3, 3'd2, 2'b10);
    wait_done();
    lat = 1;

    // FIXED 8 beats with R stalled: only FIFO_DEPTH reads may issue
    s_axi_rready = 1'b0;
    for (int k = 0; k < 8; k++) add_beat(32'h200, k, k == 7, 0, 8'h33);
    rd_count = 0;
    send_ar(8'h33, 32'h200, 8'd7, 3'd2, 2'b00);
    repeat (10) @(posedge clk);
    #1;
    chk("credit_rd_count", 64'(rd_count), 64'd4);
    chk("credit_rd_low", {63'd0, rd}, 64'd0);
    s_axi_rready = 1'b1;
    wait_done();

    // Error on beat 2 does not abort the burst
    err_beat = 2;
    for (int k = 0; k < 4; k++) add_beat(32'h40 + 32'(4 * k), k, k == 3, k == 2, 8'h44);
    send_ar(8'h44, 32'h40, 8'd3, 3'd2, 2'b01);
    wait_done();
    err_beat = -1;

    // Single beat, then back-to-back AR
    add_beat(32'h80, 0, 1, 0, 8'h55);
    send_ar(8'h55, 32'h80, 8'd0, 3'd2, 2'b01);
    wait_done();
    add_beat(32'h84, 0, 1, 0, 8'h56);
    send_ar(8'h56, 32'h84, 8'd0, 3'd2, 2'b01);
    wait_done();

    // Reset mid-burst
    for (int k = 0; k < 8; k++) add_beat(32'h300 + 32'(4 * k), k, k == 7, 0, 8'h77);
    send_ar(8'h77, 32'h300, 8'd7, 3'd2, 2'b01);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (exp_r.size() <= 6) reached = 1;
      else begin @(posedge clk); #1; end
    end
    chk("mid_burst_reached", {63'd0, reached}, 64'd1);
    rst = 1'b1;
    exp_r.delete();
    exp_a.delete();
    @(posedge clk); #1;
    chk("midrst_outputs", {61'd0, s_axi_rvalid, rd, s_axi_arready}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_arready", {63'd0, s_axi_arready}, 64'd1);
    add_beat(32'h10, 0, 0, 0, 8'h99);
    add_beat(32'h14, 1, 1, 0, 8'h99);
    send_ar(8'h99, 32'h10, 8'd1, 3'd2, 2'b01);
    wait_done();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
